// File: rtl/red_pitaya_sys_master_if.sv
// Command, response and system-bus signal bundle for red_pitaya_sys_master.
// Signal suffixes are from the initiator's point of view.
interface red_pitaya_sys_master_if #(
  parameter int unsigned AW = 32
);
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [31:0]   cmd_wdata_i;
  logic [3:0]    cmd_sel_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;

  logic [AW-1:0] sys_addr_o;
  logic [31:0]   sys_wdata_o;
  logic [3:0]    sys_sel_o;
  logic          sys_wen_o;
  logic          sys_ren_o;
  logic [31:0]   sys_rdata_i;
  logic          sys_err_i;
  logic          sys_ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_sel_i,
    input  rsp_ready_i,
    input  sys_rdata_i, sys_err_i, sys_ack_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output sys_addr_o, sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_sel_i,
    output rsp_ready_i,
    output sys_rdata_i, sys_err_i, sys_ack_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  sys_addr_o, sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o
  );
endinterface

// File: rtl/red_pitaya_sys_master.sv
// Single-outstanding system-bus initiator: one command in, one strobe out,
// wait for ack/err or timeout, one response back.
module red_pitaya_sys_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned AW             = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  red_pitaya_sys_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  // Counter value in the last WAIT cycle before a timeout is declared.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          we_d    = bus.cmd_we_i;
          addr_d  = bus.cmd_addr_i;
          wdata_d = bus.cmd_wdata_i;
          sel_d   = bus.cmd_sel_i;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ, WAIT: begin
        // Ack is checked before the timeout so a last-cycle ack still wins.
        if (bus.sys_ack_i) begin
          rdata_d = we_q ? '0 : bus.sys_rdata_i;
          err_d   = bus.sys_err_i;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (state_q == WAIT && cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready_o   = (state_q == IDLE);
  assign bus.sys_wen_o     = (state_q == REQ) &&  we_q;
  assign bus.sys_ren_o     = (state_q == REQ) && !we_q;
  assign bus.sys_addr_o    = addr_q;
  assign bus.sys_wdata_o   = wdata_q;
  assign bus.sys_sel_o     = sel_q;
  assign bus.rsp_valid_o   = (state_q == RESP);
  assign bus.rsp_rdata_o   = rdata_q;
  assign bus.rsp_err_o     = err_q;
  assign bus.rsp_timeout_o = tmo_q;

endmodule

// File: doc/red_pitaya_sys_master.md
Name: red_pitaya_sys_master

Overview:
Single-outstanding-transaction initiator for the Red Pitaya system bus. It is the master end of the same bus that housekeeping and the other register slaves respond on. It accepts read/write commands on a valid/ready interface, drives one bus access, and waits for ack or err, with a timeout. It returns read data and status on a valid/ready response interface, which lets on-chip sequencers and test harnesses access slave registers without the PS.

Parameters:
TIMEOUT_CYCLES, 16, bus cycles allowed from strobe until ack; legal range 2..255.
AW, 32, address width.

Ports:
clk_i  in  1  clock; bus and command logic share this clock
rst_i  in  1  reset, synchronous, active-high
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid & ready
cmd_we_i  in  1  1 = write, 0 = read
cmd_addr_i  in  AW  target address
cmd_wdata_i  in  32  write data
cmd_sel_i  in  4  byte select, passed through unchanged
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid & ready
rsp_rdata_o  out  32  read data; 0 for writes
rsp_err_o  out  1  slave err, or timeout
rsp_timeout_o  out  1  no ack within TIMEOUT_CYCLES
sys_addr_o  out  AW  bus address
sys_wdata_o  out  32  bus write data
sys_sel_o  out  4  bus byte select
sys_wen_o  out  1  write strobe, one-cycle pulse
sys_ren_o  out  1  read strobe, one-cycle pulse
sys_rdata_i  in  32  bus read data, valid with ack
sys_err_i  in  1  bus error, valid with ack
sys_ack_i  in  1  bus acknowledge; may be combinational in the strobe cycle

Behaviour:
- Reset (rst_i high at a clock edge):
  - FSM returns to IDLE.
  - All outputs go to 0, except cmd_ready_o, which goes to 1 in the first cycle after reset.
  - The timeout counter clears.
  - Reset mid-transaction aborts it: no response is produced and the strobe is never re-issued.
- FSM states are IDLE, REQ, WAIT, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On valid & ready, latch we/addr/wdata/sel into the sys_* registers and go to REQ.
  - cmd_ready_o = 0 in every other state (one transaction outstanding).
- REQ, exactly one cycle:
  - sys_wen_o = we or sys_ren_o = !we, never both.
  - Counter = 0.
  - If sys_ack_i is high this cycle, capture the response and go to RESP. Otherwise go to WAIT.
- WAIT:
  - Strobes are low.
  - The counter increments each cycle without ack.
  - On sys_ack_i, capture the response and go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ack in that cycle, go to RESP with rsp_timeout_o = 1, rsp_err_o = 1, rsp_rdata_o = 0.
- Response capture on ack:
  - rsp_rdata_o = sys_rdata_i for reads, 0 for writes.
  - rsp_err_o = sys_err_i.
  - rsp_timeout_o = 0.
- RESP:
  - rsp_valid_o = 1; rsp_* stay stable until rsp_ready_i.
  - On valid & ready, go to IDLE; rsp_valid_o falls the next cycle.
- sys_addr_o, sys_wdata_o and sys_sel_o hold their values from REQ until the next command is accepted.
- Latency:
  - Command accepted at cycle N → strobe at N+1.
  - Ack at N+1+d (0 ≤ d < TIMEOUT_CYCLES) → rsp_valid_o at N+2+d.
  - Timeout → rsp_valid_o at N+1+TIMEOUT_CYCLES.
  - Back-to-back minimum: accept at N, next accept at N+3 if rsp_ready_i is held high and the ack is combinational.
- sys_ack_i in IDLE or RESP is ignored; no state change.
- Ack in the cycle where the counter reaches TIMEOUT_CYCLES-1: the ack wins and no timeout is flagged.
- Command inputs while not ready are ignored and not queued.

Test Plan:
- Write, addr 0x00000030, wdata 0x0000005A, sel 0xF, combinational ack at N+1:
  - sys_wen_o high only at N+1, sys_ren_o low.
  - rsp_valid_o at N+2 with err=0, timeout=0, rdata=0.
- Read, addr 0x00000000, slave returns 0x00000001 with combinational ack:
  - sys_ren_o pulses at N+1.
  - rsp_rdata_o = 0x00000001 at N+2.
- Read, addr 0x00000FF0, ack delayed 3 cycles (ack at N+4), rdata 0x00100001:
  - rsp_valid_o at N+5, rdata 0x00100001, only one strobe pulse.
- TIMEOUT_CYCLES = 16, read with no ack ever:
  - rsp_valid_o at N+17, err=1, timeout=1, rdata=0.
  - Ack at N+16 instead → normal response at N+17, timeout=0.
- Slave returns ack with sys_err_i = 1 on a write:
  - rsp_err_o = 1, timeout = 0.
  - Hold rsp_ready_i low 5 cycles: rsp stable, cmd_ready_o low, a second cmd_valid_i is ignored.
- rst_i asserted during WAIT:
  - Next cycle: all outputs 0, no rsp_valid_o, cmd_ready_o = 1 after release.
  - A following read completes normally.
